// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the OBI round-robin memory arbiter.
package obi_arb_pkg;

    typedef enum logic [0:0] {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // A single-port ID still needs one bit of storage.
    function automatic int id_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of granted port IDs; the head names the master owed the next response.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ID_WIDTH-1:0]   push_id,
    input  logic                  pop,
    output logic [ID_WIDTH-1:0]   head,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CntW = $clog2(DEPTH) + 1;

    logic [ID_WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]     wr_ptr;
    logic [PtrW-1:0]     rd_ptr;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CntW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // When full, the slot being popped this cycle is the one the push overwrites.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_rr_mem_arbiter.sv
// N-master to 1-slave OBI arbiter with round-robin or fixed priority and in-order response routing.
module obi_rr_mem_arbiter #(
    parameter int NUM_PORTS       = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ARB_MODE        = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_PORTS-1:0]               s_req_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    s_addr_i,
    input  logic [NUM_PORTS-1:0]               s_we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  s_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    s_wdata_i,
    output logic [NUM_PORTS-1:0]               s_gnt_o,
    output logic [NUM_PORTS-1:0]               s_rvalid_o,
    output logic [DATA_WIDTH-1:0]              s_rdata_o,
    output logic [NUM_PORTS-1:0]               s_err_o,
    output logic                               m_req_o,
    output logic [ADDR_WIDTH-1:0]              m_addr_o,
    output logic                               m_we_o,
    output logic [DATA_WIDTH/8-1:0]            m_be_o,
    output logic [DATA_WIDTH-1:0]              m_wdata_o,
    input  logic                               m_gnt_i,
    input  logic                               m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]              m_rdata_i,
    input  logic                               m_err_i,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
    output logic                               unexp_rsp_o
);
    import obi_arb_pkg::*;

    localparam int IdW       = id_width(NUM_PORTS);
    localparam int BeW       = DATA_WIDTH / 8;
    localparam bit FixedMode = (ARB_MODE == int'(ARB_FIXED));

    // OBI: a transfer happens on a cycle where req and gnt are both high; the master keeps
    // req and payload stable until then. rvalid is a single-cycle response, never back-pressured.
    logic [IdW-1:0] rr_ptr;
    logic [IdW-1:0] lock_id;
    logic           locked;
    logic [IdW-1:0] pick;
    logic [IdW-1:0] idx;
    logic           found;
    logic [IdW-1:0] sel;
    logic           hs;
    logic           rsp_ok;
    logic [IdW-1:0] fifo_head;
    logic           fifo_full;
    logic           fifo_empty;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (FixedMode) begin
                idx = IdW'(k);
            end else begin
                idx = IdW'((int'(rr_ptr) + k) % NUM_PORTS);
            end
            if (!found && s_req_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // A stalled request keeps its master even if a higher-priority one shows up.
    assign sel     = locked ? lock_id : pick;
    assign m_req_o = (|s_req_i) & ~fifo_full;
    assign hs      = m_req_o & m_gnt_i;
    assign rsp_ok  = m_rvalid_i & ~fifo_empty;

    always_comb begin
        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_wdata_o = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (m_req_o && sel == IdW'(i)) begin
                m_addr_o  = s_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_we_o    = s_we_i[i];
                m_be_o    = s_be_i[i*BeW +: BeW];
                m_wdata_o = s_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign s_gnt_o    = hs ? (NUM_PORTS'(1) << sel) : '0;
    assign s_rvalid_o = rsp_ok ? (NUM_PORTS'(1) << fifo_head) : '0;
    assign s_err_o    = m_err_i ? s_rvalid_o : '0;
    assign s_rdata_o  = m_rdata_i;

    obi_arb_id_fifo #(
        .DEPTH    (MAX_OUTSTANDING),
        .ID_WIDTH (IdW)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .push    (hs),
        .push_id (sel),
        .pop     (m_rvalid_i),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (outstanding_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr      <= '0;
            locked      <= 1'b0;
            lock_id     <= '0;
            unexp_rsp_o <= 1'b0;
        end else begin
            if (m_req_o && !m_gnt_i) begin
                locked  <= 1'b1;
                lock_id <= sel;
            end else if (hs) begin
                locked  <= 1'b0;
            end
            if (hs && !FixedMode) begin
                rr_ptr <= (sel == IdW'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;
            end
            if (m_rvalid_i && fifo_empty) begin
                unexp_rsp_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_rr_mem_arbiter.sv
// Bench for obi_rr_mem_arbiter: directed scenarios on round-robin and fixed-priority instances
// plus a randomized run against a queue-based reference model.
module tb_obi_rr_mem_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NP-1:0]    req;
    logic [NP-1:0]    we;
    logic [AW-1:0]    p_addr  [NP];
    logic [BW-1:0]    p_be    [NP];
    logic [DW-1:0]    p_wdata [NP];
    logic [NP*AW-1:0] addr_bus;
    logic [NP*BW-1:0] be_bus;
    logic [NP*DW-1:0] wdata_bus;
    logic             m_gnt;
    logic             m_rvalid;
    logic [DW-1:0]    m_rdata;
    logic             m_err;

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            addr_bus[i*AW +: AW]  = p_addr[i];
            be_bus[i*BW +: BW]    = p_be[i];
            wdata_bus[i*DW +: DW] = p_wdata[i];
        end
    end

    logic [NP-1:0] gnt, rvalid, err;
    logic [DW-1:0] rdata;
    logic          m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_be;
    logic [DW-1:0] m_wdata;
    logic [2:0]    outst;
    logic          unexp;

    logic [NP-1:0] f_gnt, f_rvalid, f_err;
    logic [DW-1:0] f_rdata;
    logic          f_m_req, f_m_we;
    logic [AW-1:0] f_m_addr;
    logic [BW-1:0] f_m_be;
    logic [DW-1:0] f_m_wdata;
    logic [2:0]    f_outst;
    logic          f_unexp;

    obi_rr_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .ARB_MODE(0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .s_req_i(req), .s_addr_i(addr_bus), .s_we_i(we),
        .s_be_i(be_bus), .s_wdata_i(wdata_bus), .s_gnt_o(gnt), .s_rvalid_o(rvalid),
        .s_rdata_o(rdata), .s_err_o(err), .m_req_o(m_req), .m_addr_o(m_addr), .m_we_o(m_we),
        .m_be_o(m_be), .m_wdata_o(m_wdata), .m_gnt_i(m_gnt), .m_rvalid_i(m_rvalid),
        .m_rdata_i(m_rdata), .m_err_i(m_err), .outstanding_o(outst), .unexp_rsp_o(unexp)
    );

    obi_rr_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .ARB_MODE(1)
    ) dut_fx (
        .clk_i(clk), .rst_i(rst), .s_req_i(req), .s_addr_i(addr_bus), .s_we_i(we),
        .s_be_i(be_bus), .s_wdata_i(wdata_bus), .s_gnt_o(f_gnt), .s_rvalid_o(f_rvalid),
        .s_rdata_o(f_rdata), .s_err_o(f_err), .m_req_o(f_m_req), .m_addr_o(f_m_addr),
        .m_we_o(f_m_we), .m_be_o(f_m_be), .m_wdata_o(f_m_wdata), .m_gnt_i(m_gnt),
        .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata), .m_err_i(m_err), .outstanding_o(f_outst),
        .unexp_rsp_o(f_unexp)
    );

    int total = 0;
    int bad   = 0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p);
        p_addr[p]  = 32'hA000_0000 + (p << 8);
        we[p]      = p[0];
        p_be[p]    = 4'hF >> p;
        p_wdata[p] = 32'hD000_0000 + p;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        we       = '0;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        m_err    = 1'b0;
        for (int p = 0; p < NP; p++) begin
            p_addr[p]  = '0;
            p_be[p]    = '0;
            p_wdata[p] = '0;
        end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL reset_m_req got=%b exp=0", m_req); end
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
        total++; if (m_addr !== 32'h0) begin bad++; $display("FAIL reset_m_addr got=%h exp=0", m_addr); end
        total++; if (outst !== 3'd0) begin bad++; $display("FAIL reset_outst got=%0d exp=0", outst); end
        total++; if (unexp !== 1'b0) begin bad++; $display("FAIL reset_unexp got=%b exp=0", unexp); end
    endtask

    task automatic test_rr_fairness();
        int cnt[NP];
        logic [NP-1:0] e;
        do_reset();
        for (int p = 0; p < NP; p++) begin set_port(p); cnt[p] = 0; end
        req   = 3'b111;
        m_gnt = 1'b1;
        for (int c = 0; c < 30; c++) begin
            m_rvalid = (c > 0);
            @(negedge clk);
            e = 3'b001 << (c % NP);
            total++; if (gnt !== e) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, e); end
            if (c > 0) begin
                e = 3'b001 << ((c - 1) % NP);
                total++; if (rvalid !== e) begin bad++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", c, rvalid, e); end
            end
            for (int p = 0; p < NP; p++) if (gnt[p] === 1'b1) cnt[p]++;
            next_cycle();
        end
        for (int p = 0; p < NP; p++) begin
            total++; if (cnt[p] != 10) begin bad++; $display("FAIL rr_share port=%0d got=%0d exp=10", p, cnt[p]); end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        set_port(0);
        set_port(2);
        req   = 3'b101;
        m_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            m_rvalid = (c > 0);
            @(negedge clk);
            total++; if (f_gnt !== 3'b001) begin bad++; $display("FAIL fix_gnt cyc=%0d got=%b exp=001", c, f_gnt); end
            total++; if (f_m_addr !== 32'hA000_0000) begin bad++; $display("FAIL fix_addr cyc=%0d got=%h exp=a0000000", c, f_m_addr); end
            next_cycle();
        end
        req = 3'b100;
        @(negedge clk);
        total++; if (f_gnt !== 3'b100) begin bad++; $display("FAIL fix_gnt_low got=%b exp=100", f_gnt); end
        next_cycle();
    endtask

    task automatic test_lock();
        do_reset();
        set_port(0);
        set_port(1);
        req = 3'b010;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) req[0] = 1'b1;
            m_gnt = (c == 3);
            @(negedge clk);
            total++; if (m_addr !== 32'hA000_0100) begin bad++; $display("FAIL lock_addr cyc=%0d got=%h exp=a0000100", c, m_addr); end
            total++; if (f_m_addr !== 32'hA000_0100) begin bad++; $display("FAIL lock_addr_fx cyc=%0d got=%h exp=a0000100", c, f_m_addr); end
            if (c < 3) begin
                total++; if (gnt !== 3'b000) begin bad++; $display("FAIL lock_nogt cyc=%0d got=%b exp=000", c, gnt); end
            end else begin
                total++; if (gnt !== 3'b010) begin bad++; $display("FAIL lock_gnt got=%b exp=010", gnt); end
                total++; if (f_gnt !== 3'b010) begin bad++; $display("FAIL lock_gnt_fx got=%b exp=010", f_gnt); end
            end
            next_cycle();
        end
        req[1] = 1'b0;
        @(negedge clk);
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL lock_after got=%b exp=001", gnt); end
        next_cycle();
    endtask

    task automatic test_outstanding_limit();
        do_reset();
        set_port(0);
        req   = 3'b001;
        m_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (gnt !== 3'b001) begin bad++; $display("FAIL lim_gnt cyc=%0d got=%b exp=001", c, gnt); end
            total++; if (outst !== 3'(c)) begin bad++; $display("FAIL lim_outst cyc=%0d got=%0d exp=%0d", c, outst, c); end
            next_cycle();
        end
        @(negedge clk);
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL lim_full_req got=%b exp=0", m_req); end
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL lim_full_gnt got=%b exp=000", gnt); end
        total++; if (outst !== 3'd4) begin bad++; $display("FAIL lim_full_outst got=%0d exp=4", outst); end
        next_cycle();
        m_rvalid = 1'b1;
        @(negedge clk);
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL lim_pop_req got=%b exp=0", m_req); end
        total++; if (rvalid !== 3'b001) begin bad++; $display("FAIL lim_pop_rvalid got=%b exp=001", rvalid); end
        next_cycle();
        m_rvalid = 1'b0;
        @(negedge clk);
        total++; if (m_req !== 1'b1) begin bad++; $display("FAIL lim_resume_req got=%b exp=1", m_req); end
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL lim_resume_gnt got=%b exp=001", gnt); end
        total++; if (outst !== 3'd3) begin bad++; $display("FAIL lim_resume_outst got=%0d exp=3", outst); end
        next_cycle();
    endtask

    task automatic test_routing();
        int order[3] = '{2, 0, 1};
        logic [NP-1:0] e;
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p);
        m_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req = 3'b001 << order[k];
            @(negedge clk);
            total++; if (gnt !== req) begin bad++; $display("FAIL route_gnt k=%0d got=%b exp=%b", k, gnt, req); end
            next_cycle();
        end
        req   = '0;
        m_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hA + k;
            m_err    = (k == 1);
            @(negedge clk);
            e = 3'b001 << order[k];
            total++; if (rvalid !== e) begin bad++; $display("FAIL route_rvalid k=%0d got=%b exp=%b", k, rvalid, e); end
            e = (k == 1) ? 3'b001 : 3'b000;
            total++; if (err !== e) begin bad++; $display("FAIL route_err k=%0d got=%b exp=%b", k, err, e); end
            total++; if (rdata !== 32'hA + k) begin bad++; $display("FAIL route_rdata k=%0d got=%h exp=%h", k, rdata, 32'hA + k); end
            next_cycle();
        end
        m_rvalid = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic test_reset_unexpected();
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p);
        m_gnt = 1'b1;
        req   = 3'b001;
        next_cycle();
        req = 3'b010;
        next_cycle();
        req   = '0;
        m_gnt = 1'b0;
        @(negedge clk);
        total++; if (outst !== 3'd2) begin bad++; $display("FAIL unexp_pre_outst got=%0d exp=2", outst); end
        rst = 1'b1;
        next_cycle();
        rst      = 1'b0;
        m_rvalid = 1'b1;
        @(negedge clk);
        total++; if (rvalid !== 3'b000) begin bad++; $display("FAIL unexp_rvalid got=%b exp=000", rvalid); end
        total++; if (outst !== 3'd0) begin bad++; $display("FAIL unexp_outst got=%0d exp=0", outst); end
        next_cycle();
        m_rvalid = 1'b0;
        @(negedge clk);
        total++; if (unexp !== 1'b1) begin bad++; $display("FAIL unexp_flag got=%b exp=1", unexp); end
        next_cycle();
        @(negedge clk);
        total++; if (unexp !== 1'b1) begin bad++; $display("FAIL unexp_sticky got=%b exp=1", unexp); end
        next_cycle();
    endtask

    task automatic test_random();
        logic [1:0]    exp_q[$];
        int            rr_ptr = 0;
        int            lock = -1;
        int            s;
        int            drop;
        bit            e_req, hs;
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [BW-1:0] e_be;
        logic [DW-1:0] e_wdata;
        logic [NP-1:0] e_gnt, e_rv, e_err;
        do_reset();
        drop = -1;
        for (int c = 0; c < 400; c++) begin
            if (drop >= 0) req[drop] = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!req[p] && $urandom_range(0, 1) == 1) begin
                    req[p]     = 1'b1;
                    p_addr[p]  = $urandom;
                    we[p]      = 1'($urandom_range(0, 1));
                    p_be[p]    = 4'($urandom_range(0, 15));
                    p_wdata[p] = $urandom;
                end
            end
            m_gnt    = ($urandom_range(0, 3) != 0);
            m_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            m_rdata  = $urandom;
            m_err    = 1'($urandom_range(0, 1));
            @(negedge clk);
            e_req = (req != '0) && (exp_q.size() < MO);
            s = -1;
            if (lock >= 0) s = lock;
            else for (int k = 0; k < NP; k++) if (s < 0 && req[(rr_ptr + k) % NP]) s = (rr_ptr + k) % NP;
            if (s < 0) s = 0;
            e_addr  = e_req ? p_addr[s] : '0;
            e_we    = e_req ? we[s] : 1'b0;
            e_be    = e_req ? p_be[s] : '0;
            e_wdata = e_req ? p_wdata[s] : '0;
            hs      = e_req && m_gnt;
            e_gnt   = hs ? (3'b001 << s) : 3'b000;
            e_rv    = (m_rvalid && exp_q.size() > 0) ? (3'b001 << exp_q[0]) : 3'b000;
            e_err   = m_err ? e_rv : 3'b000;
            total++; if (m_req !== e_req) begin bad++; $display("FAIL rnd_m_req cyc=%0d got=%b exp=%b", c, m_req, e_req); end
            total++; if (m_addr !== e_addr) begin bad++; $display("FAIL rnd_m_addr cyc=%0d got=%h exp=%h", c, m_addr, e_addr); end
            total++; if (m_we !== e_we) begin bad++; $display("FAIL rnd_m_we cyc=%0d got=%b exp=%b", c, m_we, e_we); end
            total++; if (m_be !== e_be) begin bad++; $display("FAIL rnd_m_be cyc=%0d got=%h exp=%h", c, m_be, e_be); end
            total++; if (m_wdata !== e_wdata) begin bad++; $display("FAIL rnd_m_wdata cyc=%0d got=%h exp=%h", c, m_wdata, e_wdata); end
            total++; if (gnt !== e_gnt) begin bad++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", c, gnt, e_gnt); end
            total++; if (rvalid !== e_rv) begin bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", c, rvalid, e_rv); end
            total++; if (err !== e_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, err, e_err); end
            total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, rdata, m_rdata); end
            total++; if (outst !== 3'(exp_q.size())) begin bad++; $display("FAIL rnd_outst cyc=%0d got=%0d exp=%0d", c, outst, exp_q.size()); end
            total++; if (unexp !== 1'b0) begin bad++; $display("FAIL rnd_unexp cyc=%0d got=%b exp=0", c, unexp); end
            if (e_rv != '0) void'(exp_q.pop_front());
            drop = -1;
            if (hs) begin
                exp_q.push_back(2'(s));
                rr_ptr = (s + 1) % NP;
                lock   = -1;
                drop   = s;
            end else if (e_req) begin
                lock = s;
            end
            next_cycle();
        end
        req      = '0;
        m_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_lock();
        test_outstanding_limit();
        test_routing();
        test_reset_unexpected();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
